// File: rtl/psram_scheduler.sv
// Power-up sequencer and round-robin access arbiter in front of the PSRAM byte engine.
// Runs init wait, 0x66/0x99 reset, Read-ID check, then serves 32-bit reads/writes from two requesters.
module psram_scheduler #(
  parameter int          INIT_WAIT_CYCLES = 4050,
  parameter int          RST_WAIT_CYCLES  = 8,
  parameter logic [7:0]  EXPECT_MFID      = 8'h0D,
  parameter logic [7:0]  EXPECT_KGD       = 8'h5D
) (
  input  logic        sys_clk,
  input  logic        sys_reset_n,
  input  logic        req0_valid,
  output logic        req0_ready,
  input  logic        req0_we,
  input  logic [22:0] req0_addr,
  input  logic [31:0] req0_wdata,
  input  logic        req1_valid,
  output logic        req1_ready,
  input  logic        req1_we,
  input  logic [22:0] req1_addr,
  input  logic [31:0] req1_wdata,
  output logic        rsp_valid,
  output logic        rsp_id,
  output logic [31:0] rsp_rdata,
  output logic        eng_tx_valid,
  input  logic        eng_tx_ready,
  output logic [7:0]  eng_tx_data,
  output logic        eng_tx_last,
  input  logic        eng_rx_valid,
  input  logic [7:0]  eng_rx_data,
  output logic        init_done,
  output logic        init_error,
  output logic [3:0]  dbg_state
);

  localparam logic [3:0] S_INIT_WAIT = 4'd0,  S_RST_EN  = 4'd1,  S_RST     = 4'd2,
                         S_RST_WAIT  = 4'd3,  S_RDID    = 4'd4,  S_IDLE    = 4'd5,
                         S_CMD       = 4'd6,  S_ADDR    = 4'd7,  S_DATA    = 4'd8,
                         S_WAIT_RX   = 4'd9,  S_RESP    = 4'd10, S_ERROR   = 4'd11;

  // Handshakes: a byte/request moves on a clock edge where valid and ready are both high;
  // the offering side keeps valid and its payload unchanged until that edge.

  logic [3:0]  state;
  logic [15:0] wait_cnt;
  logic [3:0]  tx_cnt;
  logic [3:0]  rx_cnt;
  logic        last_grant;
  logic        cur_id;
  logic        cur_we;
  logic [22:0] cur_addr;
  logic [31:0] cur_wdata;
  logic [31:0] rdata;
  logic [7:0]  mfid;
  logic [7:0]  kgd;

  logic        tx_state;
  logic        acc_state;
  logic [3:0]  frame_len;
  logic        grant_any;
  logic        grant_id;
  logic        accept;
  logic        rx_take;
  logic        frame_done;

  function automatic logic [7:0] byte_at(input logic [3:0] st, input logic [3:0] idx,
                                         input logic we, input logic [22:0] addr,
                                         input logic [31:0] wdata);
    byte_at = 8'h00;
    case (st)
      S_RST_EN: byte_at = 8'h66;
      S_RST:    byte_at = 8'h99;
      S_RDID: begin
        if (idx == 4'd0) byte_at = 8'h9F;
        else if (idx >= 4'd4) byte_at = 8'hFF;
      end
      default: begin
        case (idx)
          4'd0: byte_at = we ? 8'h02 : 8'h03;
          4'd1: byte_at = {1'b0, addr[22:16]};
          4'd2: byte_at = addr[15:8];
          4'd3: byte_at = addr[7:0];
          4'd4: byte_at = we ? wdata[7:0]   : 8'h00;
          4'd5: byte_at = we ? wdata[15:8]  : 8'h00;
          4'd6: byte_at = we ? wdata[23:16] : 8'h00;
          4'd7: byte_at = we ? wdata[31:24] : 8'h00;
          default: byte_at = 8'h00;
        endcase
      end
    endcase
  endfunction

  always_comb begin
    tx_state  = (state == S_RST_EN) || (state == S_RST) || (state == S_RDID) ||
                (state == S_CMD) || (state == S_ADDR) || (state == S_DATA);
    acc_state = (state == S_CMD) || (state == S_ADDR) || (state == S_DATA) || (state == S_WAIT_RX);
    case (state)
      S_RST_EN, S_RST: frame_len = 4'd1;
      S_RDID:          frame_len = 4'd6;
      default:         frame_len = 4'd8;
    endcase
    grant_any  = req0_valid | req1_valid;
    grant_id   = (req0_valid & req1_valid) ? ~last_grant : req1_valid;
    req0_ready = (state == S_IDLE) && grant_any && !grant_id;
    req1_ready = (state == S_IDLE) && grant_any && grant_id;
    accept     = eng_tx_valid && eng_tx_ready;
    // Only count rx pulses for bytes the engine has actually taken.
    rx_take    = eng_rx_valid && (rx_cnt < tx_cnt);
    frame_done = !eng_tx_valid && (tx_cnt == frame_len) && (rx_cnt == frame_len);
  end

  assign rsp_valid = (state == S_RESP);
  assign rsp_id    = cur_id;
  assign rsp_rdata = rdata;
  assign dbg_state = state;

  always_ff @(posedge sys_clk or negedge sys_reset_n) begin
    if (!sys_reset_n) begin
      state        <= S_INIT_WAIT;
      wait_cnt     <= '0;
      tx_cnt       <= '0;
      rx_cnt       <= '0;
      last_grant   <= 1'b1;
      cur_id       <= 1'b0;
      cur_we       <= 1'b0;
      cur_addr     <= '0;
      cur_wdata    <= '0;
      rdata        <= '0;
      mfid         <= '0;
      kgd          <= '0;
      eng_tx_valid <= 1'b0;
      eng_tx_data  <= '0;
      eng_tx_last  <= 1'b0;
      init_done    <= 1'b0;
      init_error   <= 1'b0;
    end else begin
      if (accept) begin
        tx_cnt <= tx_cnt + 4'd1;
        if (eng_tx_last) begin
          eng_tx_valid <= 1'b0;
        end else begin
          eng_tx_data <= byte_at(state, tx_cnt + 4'd1, cur_we, cur_addr, cur_wdata);
          eng_tx_last <= (tx_cnt + 4'd1 == frame_len - 4'd1);
        end
      end else if (tx_state && !eng_tx_valid && (tx_cnt < frame_len)) begin
        eng_tx_valid <= 1'b1;
        eng_tx_data  <= byte_at(state, tx_cnt, cur_we, cur_addr, cur_wdata);
        eng_tx_last  <= (tx_cnt == frame_len - 4'd1);
      end

      if (rx_take) begin
        rx_cnt <= rx_cnt + 4'd1;
        if (state == S_RDID && rx_cnt == 4'd4) mfid <= eng_rx_data;
        if (state == S_RDID && rx_cnt == 4'd5) kgd  <= eng_rx_data;
        // Read data arrives on rx bytes 4..7, least significant byte first.
        if (acc_state && !cur_we && rx_cnt[2]) rdata[{rx_cnt[1:0], 3'b000} +: 8] <= eng_rx_data;
      end

      case (state)
        S_INIT_WAIT: begin
          if (wait_cnt == 16'(INIT_WAIT_CYCLES - 1)) begin
            wait_cnt <= '0;
            state    <= S_RST_EN;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        S_RST_EN: if (frame_done) begin
          tx_cnt <= '0; rx_cnt <= '0; state <= S_RST;
        end
        S_RST: if (frame_done) begin
          tx_cnt <= '0; rx_cnt <= '0; state <= S_RST_WAIT;
        end
        S_RST_WAIT: begin
          if (wait_cnt == 16'(RST_WAIT_CYCLES - 1)) begin
            wait_cnt <= '0;
            state    <= S_RDID;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
        end
        S_RDID: if (frame_done) begin
          tx_cnt <= '0;
          rx_cnt <= '0;
          if (mfid == EXPECT_MFID && kgd == EXPECT_KGD) begin
            init_done <= 1'b1;
            state     <= S_IDLE;
          end else begin
            init_error <= 1'b1;
            state      <= S_ERROR;
          end
        end
        S_IDLE: if (grant_any) begin
          cur_id     <= grant_id;
          last_grant <= grant_id;
          cur_we     <= grant_id ? req1_we    : req0_we;
          cur_addr   <= grant_id ? req1_addr  : req0_addr;
          cur_wdata  <= grant_id ? req1_wdata : req0_wdata;
          rdata      <= '0;
          tx_cnt     <= '0;
          rx_cnt     <= '0;
          state      <= S_CMD;
        end
        S_CMD:     if (accept) state <= S_ADDR;
        S_ADDR:    if (accept && tx_cnt == 4'd3) state <= S_DATA;
        S_DATA:    if (accept && eng_tx_last) state <= S_WAIT_RX;
        S_WAIT_RX: if (rx_cnt == 4'd8) state <= S_RESP;
        S_RESP: begin
          tx_cnt <= '0;
          rx_cnt <= '0;
          state  <= S_IDLE;
        end
        S_ERROR: state <= S_ERROR;
        default: state <= S_ERROR;
      endcase
    end
  end

endmodule

// File: tb/tb_psram_scheduler.sv
// Directed bench for psram_scheduler: init sequence, single accesses, round-robin,
// stalls, reset mid-frame and the Read-ID failure path, with a simple engine model.
module tb_psram_scheduler;

  logic        sys_clk = 1'b0;
  logic        sys_reset_n = 1'b1;
  logic        req0_valid = 1'b0, req0_we = 1'b0;
  logic [22:0] req0_addr = '0;
  logic [31:0] req0_wdata = '0;
  logic        req1_valid = 1'b0, req1_we = 1'b0;
  logic [22:0] req1_addr = '0;
  logic [31:0] req1_wdata = '0;
  logic        req0_ready, req1_ready;
  logic        rsp_valid, rsp_id;
  logic [31:0] rsp_rdata;
  logic        eng_tx_valid, eng_tx_last;
  logic [7:0]  eng_tx_data;
  logic        eng_tx_ready;
  logic        eng_rx_valid;
  logic [7:0]  eng_rx_data;
  logic        init_done, init_error;
  logic [3:0]  dbg_state;

  psram_scheduler dut (
    .sys_clk(sys_clk), .sys_reset_n(sys_reset_n),
    .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
    .req0_addr(req0_addr), .req0_wdata(req0_wdata),
    .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
    .req1_addr(req1_addr), .req1_wdata(req1_wdata),
    .rsp_valid(rsp_valid), .rsp_id(rsp_id), .rsp_rdata(rsp_rdata),
    .eng_tx_valid(eng_tx_valid), .eng_tx_ready(eng_tx_ready),
    .eng_tx_data(eng_tx_data), .eng_tx_last(eng_tx_last),
    .eng_rx_valid(eng_rx_valid), .eng_rx_data(eng_rx_data),
    .init_done(init_done), .init_error(init_error), .dbg_state(dbg_state)
  );

  // Clock and cycle counter
  always #5 sys_clk = ~sys_clk;
  int cyc = 0;
  always @(posedge sys_clk) cyc <= cyc + 1;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Scoreboard: expected tx bytes {last,data} and responses {id,rdata}
  logic [8:0]  exp_q[$];
  logic [32:0] exp_rsp_q[$];
  logic [7:0]  rx_q[$];
  logic [7:0]  resp_b[8];
  int          pos = 0;
  int          rel_cyc = 0;
  int          first_tx_cyc = 0;
  bit          seen_first = 0;
  bit          held_valid = 0;
  logic [8:0]  held = '0;
  bit          stall_en = 0;
  bit          rx_rand = 0;
  int          ready0_cnt = 0;

  // Engine model: ready/rx driven just after each rising edge
  initial begin
    eng_tx_ready = 1'b0;
    eng_rx_valid = 1'b0;
    eng_rx_data  = 8'h00;
    forever begin
      @(posedge sys_clk);
      #1;
      eng_tx_ready = stall_en ? 1'($urandom_range(0, 1)) : 1'b1;
      eng_rx_valid = 1'b0;
      if (sys_reset_n && rx_q.size() > 0 && (!rx_rand || $urandom_range(0, 2) == 0)) begin
        eng_rx_valid = 1'b1;
        eng_rx_data  = rx_q.pop_front();
      end
    end
  end

  // Monitor on the falling edge: tx stability, tx bytes, responses
  always @(negedge sys_clk) begin
    if (sys_reset_n) begin
      if (req0_ready) ready0_cnt++;
      if (held_valid) check("tx_hold", {eng_tx_valid, eng_tx_last, eng_tx_data}, {1'b1, held});
      if (eng_tx_valid && !seen_first) begin
        seen_first   = 1;
        first_tx_cyc = cyc;
      end
      if (eng_tx_valid && eng_tx_ready) begin
        if (exp_q.size() == 0) check("tx_expected", exp_q.size(), 1);
        else check("tx_byte", {eng_tx_last, eng_tx_data}, exp_q.pop_front());
        rx_q.push_back(resp_b[pos]);
        pos = eng_tx_last ? 0 : (pos + 1) % 8;
      end
      held_valid = eng_tx_valid && !eng_tx_ready;
      held       = {eng_tx_last, eng_tx_data};
      if (rsp_valid) begin
        if (exp_rsp_q.size() == 0) check("rsp_expected", exp_rsp_q.size(), 1);
        else check("rsp", {rsp_id, rsp_rdata}, exp_rsp_q.pop_front());
      end
    end
  end

  task automatic assert_reset();
    sys_reset_n = 1'b0;
    held_valid  = 0;
    seen_first  = 0;
    pos         = 0;
    rx_q.delete();
    exp_q.delete();
    exp_rsp_q.delete();
  endtask

  task automatic release_reset();
    repeat (3) @(posedge sys_clk);
    #1 sys_reset_n = 1'b1;
    rel_cyc = cyc;
  endtask

  task automatic push8(input logic [7:0] b0, b1, b2, b3, b4, b5, b6, b7);
    exp_q.push_back({1'b0, b0}); exp_q.push_back({1'b0, b1});
    exp_q.push_back({1'b0, b2}); exp_q.push_back({1'b0, b3});
    exp_q.push_back({1'b0, b4}); exp_q.push_back({1'b0, b5});
    exp_q.push_back({1'b0, b6}); exp_q.push_back({1'b1, b7});
  endtask

  task automatic push_init();
    exp_q.push_back(9'h166);
    exp_q.push_back(9'h199);
    exp_q.push_back(9'h09F); exp_q.push_back(9'h000);
    exp_q.push_back(9'h000); exp_q.push_back(9'h000);
    exp_q.push_back(9'h0FF); exp_q.push_back(9'h1FF);
  endtask

  task automatic wait_init();
    bit hit = 0;
    for (int i = 0; i < 6000; i++) begin
      @(negedge sys_clk);
      if (init_done || init_error) begin
        hit = 1;
        break;
      end
    end
    check("init_reached", hit, 1);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 3000; i++) begin
      @(negedge sys_clk);
      if (exp_q.size() == 0 && exp_rsp_q.size() == 0) break;
    end
    check("drain_tx_left", exp_q.size(), 0);
    check("drain_rsp_left", exp_rsp_q.size(), 0);
  endtask

  // Driver: raise valid, hold it through the accepting edge, then drop it
  task automatic do_req(input int id, input logic we, input logic [22:0] addr,
                        input logic [31:0] wdata);
    bit ok = 0;
    @(posedge sys_clk);
    #1;
    if (id == 0) begin
      req0_valid = 1'b1; req0_we = we; req0_addr = addr; req0_wdata = wdata;
    end else begin
      req1_valid = 1'b1; req1_we = we; req1_addr = addr; req1_wdata = wdata;
    end
    for (int i = 0; i < 2000; i++) begin
      @(negedge sys_clk);
      if ((id == 0 && req0_ready) || (id == 1 && req1_ready)) begin
        ok = 1;
        break;
      end
    end
    check(id == 0 ? "req0_granted" : "req1_granted", ok, 1);
    @(posedge sys_clk);
    #1;
    if (id == 0) req0_valid = 1'b0;
    else req1_valid = 1'b0;
  endtask

  initial begin
    bit hit;
    #3;
    assert_reset();
    resp_b = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h0D, 8'h5D, 8'h00, 8'h00};
    @(negedge sys_clk);
    check("rst_tx_valid", eng_tx_valid, 0);
    check("rst_init_done", init_done, 0);
    check("rst_init_error", init_error, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_state", dbg_state, 4'd0);

    // Power-up init with a good ID
    push_init();
    release_reset();
    wait_init();
    check("pu_init_done", init_done, 1);
    check("pu_init_error", init_error, 0);
    check("pu_first_tx_delay_ok", (first_tx_cyc - rel_cyc) >= 4050, 1);
    check("pu_tx_left", exp_q.size(), 0);
    check("pu_state_idle", dbg_state, 4'd5);

    // Single write from requester 0
    push8(8'h02, 8'h01, 8'h23, 8'h45, 8'hEF, 8'hBE, 8'hAD, 8'hDE);
    exp_rsp_q.push_back({1'b0, 32'h0000_0000});
    do_req(0, 1'b1, 23'h012345, 32'hDEADBEEF);
    wait_drain();

    // Single read from requester 1 at the top address
    resp_b = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'h33, 8'h44};
    push8(8'h03, 8'h7F, 8'hFF, 8'hFF, 8'h00, 8'h00, 8'h00, 8'h00);
    exp_rsp_q.push_back({1'b1, 32'h4433_2211});
    do_req(1, 1'b0, 23'h7FFFFF, 32'h0);
    wait_drain();

    // Both requesters busy, with engine stalls: grants alternate 0,1,0,1
    stall_en = 1;
    rx_rand  = 1;
    push8(8'h02, 8'h00, 8'h01, 8'h00, 8'h04, 8'h03, 8'h02, 8'h01);
    push8(8'h03, 8'h40, 8'h00, 8'h80, 8'h00, 8'h00, 8'h00, 8'h00);
    push8(8'h02, 8'h7F, 8'hFF, 8'hFE, 8'h5A, 8'h5A, 8'hA5, 8'hA5);
    push8(8'h03, 8'h00, 8'h00, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00);
    exp_rsp_q.push_back({1'b0, 32'h0});
    exp_rsp_q.push_back({1'b1, 32'h4433_2211});
    exp_rsp_q.push_back({1'b0, 32'h0});
    exp_rsp_q.push_back({1'b1, 32'h4433_2211});
    fork
      begin
        do_req(0, 1'b1, 23'h000100, 32'h0102_0304);
        do_req(0, 1'b1, 23'h7FFFFE, 32'hA5A5_5A5A);
      end
      begin
        do_req(1, 1'b0, 23'h400080, 32'h0);
        do_req(1, 1'b0, 23'h000001, 32'h0);
      end
    join
    wait_drain();
    stall_en = 0;
    rx_rand  = 0;

    // Reset in the middle of the data phase
    push8(8'h02, 8'h00, 8'h00, 8'h10, 8'h78, 8'h56, 8'h34, 8'h12);
    do_req(0, 1'b1, 23'h000010, 32'h1234_5678);
    hit = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge sys_clk);
      if (dbg_state == 4'd8 && eng_tx_valid) begin
        hit = 1;
        break;
      end
    end
    check("mid_reached_data", hit, 1);
    assert_reset();
    resp_b = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h0D, 8'h5D, 8'h00, 8'h00};
    #1;
    check("mid_tx_valid_drop", eng_tx_valid, 0);
    check("mid_state", dbg_state, 4'd0);
    push_init();
    release_reset();
    wait_init();
    check("mid_init_done", init_done, 1);
    check("mid_tx_left", exp_q.size(), 0);

    // Bad known-good-die byte; requests must never be granted
    assert_reset();
    resp_b = '{8'h00, 8'h00, 8'h00, 8'h00, 8'h0D, 8'h55, 8'h00, 8'h00};
    push_init();
    ready0_cnt = 0;
    req0_valid = 1'b1; req0_we = 1'b1; req0_addr = 23'h000004; req0_wdata = 32'h0;
    release_reset();
    wait_init();
    repeat (1000) @(negedge sys_clk);
    check("err_init_error", init_error, 1);
    check("err_init_done", init_done, 0);
    check("err_state", dbg_state, 4'd11);
    check("err_ready_count", ready0_cnt, 0);
    check("err_tx_left", exp_q.size(), 0);
    req0_valid = 1'b0;

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #2_000_000;
    errors++;
    $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
